// File: rtl/mem_arb_pkg.sv
// Shared constants for the unified-memory arbiter: FSM state encodings and
// owner codes used by the top level and the grant selector.
// No logic, no latency, no flow control.
package mem_arb_pkg;

    // FSM encodings (plain constants so older tools and wave viewers agree)
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Grant owner codes
    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_DM = 1'b1;

    // Width of the consecutive-data-grant counter
    localparam int CONSEC_W = 4;

endpackage

// File: rtl/mem_arb_grant.sv
// Picks the winner between fetch and data and tracks consecutive data grants.
// Latency: winner is combinational from the requests; the counter updates on grant_i.
// Backpressure: none; the caller decides when a grant is taken via grant_i.
//
// Ports: clk, reset (async, active-low), if_req_i / dm_req_i (requests),
//        grant_i (a grant is taken this cycle), winner_o (OWN_IF / OWN_DM).
module mem_arb_grant
    import mem_arb_pkg::*;
#(
    parameter int MAX_CONSEC = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic if_req_i,
    input  logic dm_req_i,
    input  logic grant_i,
    output logic winner_o
);

    localparam logic [CONSEC_W-1:0] MAX_C = CONSEC_W'(MAX_CONSEC);

    logic [CONSEC_W-1:0] consec_q;
    logic [CONSEC_W-1:0] consec_d;
    logic                starve;

    // Fetch has waited through MAX_CONSEC data grants: it takes this one.
    assign starve   = (consec_q == MAX_C) && if_req_i;
    assign winner_o = (dm_req_i && !starve) ? OWN_DM : OWN_IF;

    always_comb begin
        consec_d = consec_q;
        if (grant_i) begin
            if ((winner_o == OWN_DM) && if_req_i) begin
                consec_d = (consec_q == MAX_C) ? consec_q : consec_q + 1'b1;
            end else begin
                consec_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            consec_q <= '0;
        end else begin
            consec_q <= consec_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one fixed-latency single-port memory between instruction fetch and data access.
// Latency: read acks in cycle LATENCY+2 after the request is sampled, write acks in cycle 2.
// Backpressure: requesters hold req until their one-cycle ack; requests are sampled only in IDLE.
//
// Ports: clk, reset (async, active-low); fetch side if_req/if_addr/if_ack/if_rdata;
//        data side dm_req/dm_we/dm_addr/dm_wdata/dm_ack/dm_rdata;
//        memory side mem_en/mem_we/mem_addr/mem_wdata/mem_rdata; status busy/owner.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int LATENCY    = 2,
    parameter int MAX_CONSEC = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ack,
    output logic [DW-1:0] if_rdata,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_ack,
    output logic [DW-1:0] dm_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          owner
);

    // Wait counter starts at LATENCY-1 so capture lands LATENCY cycles after ISSUE.
    localparam logic [2:0] WCNT_LOAD = 3'(LATENCY - 1);

    logic [1:0]    state_q, state_d;
    logic [2:0]    wcnt_q, wcnt_d;
    logic          owner_q;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] if_rdata_q;
    logic [DW-1:0] dm_rdata_q;
    logic          grant;
    logic          winner;
    logic          capture;

    assign grant = (state_q == ST_IDLE) && (if_req || dm_req);

    mem_arb_grant #(
        .MAX_CONSEC (MAX_CONSEC)
    ) u_grant (
        .clk      (clk),
        .reset    (reset),
        .if_req_i (if_req),
        .dm_req_i (dm_req),
        .grant_i  (grant),
        .winner_o (winner)
    );

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        capture = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (we_q) begin
                    state_d = ST_DONE;
                end else begin
                    // Reads always visit WAIT, even with LATENCY = 1 (wcnt = 0).
                    wcnt_d  = WCNT_LOAD;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (wcnt_q == 3'd0) begin
                    capture = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    wcnt_d = wcnt_q - 3'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            wcnt_q     <= '0;
            owner_q    <= OWN_IF;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            if (grant) begin
                owner_q <= winner;
                we_q    <= (winner == OWN_DM) && dm_we;
                addr_q  <= (winner == OWN_DM) ? dm_addr : if_addr;
                wdata_q <= (winner == OWN_DM) ? dm_wdata : '0;
            end
            if (capture) begin
                if (owner_q == OWN_DM) dm_rdata_q <= mem_rdata;
                else                   if_rdata_q <= mem_rdata;
            end
        end
    end

    assign mem_en    = (state_q == ST_ISSUE);
    assign mem_we    = mem_en && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign if_ack    = (state_q == ST_DONE) && (owner_q == OWN_IF);
    assign dm_ack    = (state_q == ST_DONE) && (owner_q == OWN_DM);
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign busy      = (state_q != ST_IDLE);
    assign owner     = owner_q;

endmodule
